// File: rtl/countdown_ctrl.sv
// MM:SS BCD countdown-timer controller: preset entry, run/pause/done sequencing, alarm.
// Optional COUNTDOWN_AUTO_RELOAD_EN: the count reloads the preset at 00:00 and keeps running.
module countdown_ctrl #(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_start,
  input  logic       key_inc,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] state,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] MAX_MIN_T  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_O  = 4'(MAX_MIN % 10);
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     st;
  logic [3:0] p_mt, p_mo, p_so;
  logic [2:0] p_st;
  logic [3:0] c_mt, c_mo, c_so;
  logic [2:0] c_st;
  logic [7:0] alarm_cnt;

  logic [3:0] d_mt, d_mo, d_so;
  logic [2:0] d_st;
  logic       preset_zero, count_zero, count_one;

  assign preset_zero = (p_mt == 4'd0) && (p_mo == 4'd0) && (p_st == 3'd0) && (p_so == 4'd0);
  assign count_zero  = (c_mt == 4'd0) && (c_mo == 4'd0) && (c_st == 3'd0) && (c_so == 4'd0);
  assign count_one   = (c_mt == 4'd0) && (c_mo == 4'd0) && (c_st == 3'd0) && (c_so == 4'd1);

  // BCD decrement with borrow ripple; only applied while the count is above 00:01.
  always_comb begin
    d_so = c_so - 4'd1;
    d_st = c_st;
    d_mo = c_mo;
    d_mt = c_mt;
    if (c_so == 4'd0) begin
      d_so = 4'd9;
      d_st = c_st - 3'd1;
      if (c_st == 3'd0) begin
        d_st = 3'd5;
        d_mo = c_mo - 4'd1;
        if (c_mo == 4'd0) begin
          d_mo = 4'd9;
          d_mt = c_mt - 4'd1;
        end
      end
    end
  end

  // Keys are single-cycle pulses; priority key_mode > key_start > key_inc, losers dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      p_mt      <= 4'd0;
      p_mo      <= 4'd0;
      p_st      <= 3'd0;
      p_so      <= 4'd0;
      c_mt      <= 4'd0;
      c_mo      <= 4'd0;
      c_st      <= 3'd0;
      c_so      <= 4'd0;
      alarm_cnt <= 8'd0;
      alarm     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (key_mode) begin
            st <= SET_MIN;
          end else if (key_start && !preset_zero) begin
            st   <= RUN;
            c_mt <= p_mt;
            c_mo <= p_mo;
            c_st <= p_st;
            c_so <= p_so;
          end
        end
        SET_MIN: begin
          if (key_mode) begin
            st <= SET_SEC;
          end else if (key_inc && !key_start) begin
            if (p_mt == MAX_MIN_T && p_mo == MAX_MIN_O) begin
              p_mt <= 4'd0;
              p_mo <= 4'd0;
            end else if (p_mo == 4'd9) begin
              p_mo <= 4'd0;
              p_mt <= p_mt + 4'd1;
            end else begin
              p_mo <= p_mo + 4'd1;
            end
          end
        end
        SET_SEC: begin
          if (key_mode) begin
            st <= IDLE;
          end else if (key_inc && !key_start) begin
            if (p_so == 4'd9) begin
              p_so <= 4'd0;
              p_st <= (p_st == 3'd5) ? 3'd0 : p_st + 3'd1;
            end else begin
              p_so <= p_so + 4'd1;
            end
          end
        end
        RUN: begin
          if (key_mode) begin
            st   <= IDLE;
            c_mt <= p_mt;
            c_mo <= p_mo;
            c_st <= p_st;
            c_so <= p_so;
          end else if (key_start) begin
            st <= PAUSE;
          end else if (tick) begin
            if (count_one) begin
              done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              c_mt <= p_mt;
              c_mo <= p_mo;
              c_st <= p_st;
              c_so <= p_so;
`else
              c_so  <= 4'd0;
              st    <= DONE;
              alarm <= 1'b1;
`endif
            end else if (!count_zero) begin
              c_mt <= d_mt;
              c_mo <= d_mo;
              c_st <= d_st;
              c_so <= d_so;
            end
          end
        end
        PAUSE: begin
          if (key_mode) begin
            st   <= IDLE;
            c_mt <= p_mt;
            c_mo <= p_mo;
            c_st <= p_st;
            c_so <= p_so;
          end else if (key_start) begin
            st <= RUN;
          end
        end
        DONE: begin
          if (key_mode || key_start || (tick && alarm_cnt == ALARM_LAST)) begin
            st        <= IDLE;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
          end else if (tick) begin
            alarm_cnt <= alarm_cnt + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  logic show_count;
  assign show_count = (st == RUN) || (st == PAUSE) || (st == DONE);
  assign min_tens   = show_count ? c_mt : p_mt;
  assign min_ones   = show_count ? c_mo : p_mo;
  assign sec_tens   = show_count ? c_st : p_st;
  assign sec_ones   = show_count ? c_so : p_so;
  assign state      = st;
  assign running    = (st == RUN);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl; each task drives one scenario and checks inline.
// Define COUNTDOWN_AUTO_RELOAD_EN for both files to exercise the auto-reload build.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_start = 1'b0;
  logic       key_inc = 1'b0;
  logic [3:0] min_tens, min_ones, sec_ones;
  logic [2:0] sec_tens;
  logic [2:0] state;
  logic       running, alarm, done;
  logic [15:0] disp;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  countdown_ctrl #(.MAX_MIN(59), .ALARM_TICKS(10)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .key_mode(key_mode), .key_start(key_start), .key_inc(key_inc),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .running(running), .alarm(alarm), .done(done)
  );

  // Display as a hex word MM:SS, e.g. 03:05 -> 16'h0305.
  assign disp = {min_tens, min_ones, 1'b0, sec_tens, sec_ones};

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run time exceeded, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  // Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic m, input logic s, input logic i, input logic t);
    @(negedge clk);
    key_mode = m; key_start = s; key_inc = i; tick = t;
    @(posedge clk);
    #1;
    key_mode = 1'b0; key_start = 1'b0; key_inc = 1'b0; tick = 1'b0;
  endtask

  task automatic press_mode();  step(1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic press_start(); step(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // From IDLE, enter a preset of mm minutes and ss seconds and return to IDLE.
  task automatic load_preset(input int mm, input int ss);
    do_reset();
    press_mode();
    press_inc(mm);
    press_mode();
    press_inc(ss);
    press_mode();
  endtask

  task automatic test_reset();
    ticks(1);
    do_reset();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL reset_disp got=%h exp=0000", disp); end
    vectors++; if (alarm !== 1'b0 || done !== 1'b0 || running !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got alarm=%b done=%b running=%b exp=000", alarm, done, running); end
  endtask

  task automatic test_set_preset();
    do_reset();
    press_mode();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL set_min_state got=%0d exp=1", state); end
    press_inc(3);
    press_mode();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL set_sec_state got=%0d exp=2", state); end
    press_inc(5);
    press_mode();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL set_idle_state got=%0d exp=0", state); end
    vectors++; if (disp !== 16'h0305) begin miscompares++; $display("FAIL set_disp got=%h exp=0305", disp); end
  endtask

  task automatic test_countdown();
    logic [15:0] e;
    load_preset(0, 3);
    press_start();
    vectors++; if (state !== 3'd3 || running !== 1'b1) begin
      miscompares++; $display("FAIL run_enter got state=%0d running=%b exp=3/1", state, running); end
    vectors++; if (disp !== 16'h0003) begin miscompares++; $display("FAIL run_load got=%h exp=0003", disp); end
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
    for (int k = 0; k < 3; k++) begin
      ticks(1);
      e = exp_q.pop_front();
      vectors++; if (disp !== e) begin miscompares++; $display("FAIL count_tick%0d got=%h exp=%h", k + 1, disp, e); end
      vectors++; if (done !== (k == 2)) begin miscompares++; $display("FAIL done_tick%0d got=%b exp=%b", k + 1, done, k == 2); end
    end
    vectors++; if (state !== 3'd5 || alarm !== 1'b1 || running !== 1'b0) begin
      miscompares++; $display("FAIL done_enter got state=%0d alarm=%b running=%b exp=5/1/0", state, alarm, running); end
    ticks(9);
    vectors++; if (alarm !== 1'b1 || state !== 3'd5) begin
      miscompares++; $display("FAIL alarm_hold got alarm=%b state=%0d exp=1/5", alarm, state); end
    ticks(1);
    vectors++; if (alarm !== 1'b0 || state !== 3'd0) begin
      miscompares++; $display("FAIL alarm_expire got alarm=%b state=%0d exp=0/0", alarm, state); end
    vectors++; if (disp !== 16'h0003) begin miscompares++; $display("FAIL preset_kept got=%h exp=0003", disp); end
    press_start();
    vectors++; if (state !== 3'd3 || disp !== 16'h0003) begin
      miscompares++; $display("FAIL rerun got state=%0d disp=%h exp=3/0003", state, disp); end
    press_mode();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL run_cancel got=%0d exp=0", state); end
  endtask

  task automatic test_done_ack();
    load_preset(0, 1);
    press_start();
    ticks(1);
    vectors++; if (state !== 3'd5 || done !== 1'b1) begin
      miscompares++; $display("FAIL ack_enter got state=%0d done=%b exp=5/1", state, done); end
    ticks(3);
    press_start();
    vectors++; if (state !== 3'd0 || alarm !== 1'b0) begin
      miscompares++; $display("FAIL ack_start got state=%0d alarm=%b exp=0/0", state, alarm); end
    press_start();
    ticks(1);
    ticks(9);
    vectors++; if (alarm !== 1'b1) begin miscompares++; $display("FAIL ack_cnt_clear got alarm=%b exp=1", alarm); end
    ticks(1);
    vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL ack_expire got alarm=%b exp=0", alarm); end
    press_start();
    ticks(1);
    press_mode();
    vectors++; if (state !== 3'd0 || alarm !== 1'b0) begin
      miscompares++; $display("FAIL ack_mode got state=%0d alarm=%b exp=0/0", state, alarm); end
  endtask

  task automatic test_borrow();
    load_preset(1, 0);
    press_start();
    ticks(1);
    vectors++; if (disp !== 16'h0059) begin miscompares++; $display("FAIL borrow got=%h exp=0059", disp); end
    load_preset(10, 0);
    press_start();
    ticks(1);
    vectors++; if (disp !== 16'h0959) begin miscompares++; $display("FAIL borrow_tens got=%h exp=0959", disp); end
  endtask

  task automatic test_pause();
    load_preset(0, 40);
    press_start();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    vectors++; if (state !== 3'd4 || disp !== 16'h0040) begin
      miscompares++; $display("FAIL pause_enter got state=%0d disp=%h exp=4/0040", state, disp); end
    ticks(5);
    vectors++; if (state !== 3'd4 || disp !== 16'h0040) begin
      miscompares++; $display("FAIL pause_hold got state=%0d disp=%h exp=4/0040", state, disp); end
    press_start();
    vectors++; if (state !== 3'd3 || running !== 1'b1) begin
      miscompares++; $display("FAIL resume got state=%0d running=%b exp=3/1", state, running); end
    ticks(1);
    vectors++; if (disp !== 16'h0039) begin miscompares++; $display("FAIL resume_tick got=%h exp=0039", disp); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    vectors++; if (state !== 3'd0 || disp !== 16'h0040) begin
      miscompares++; $display("FAIL cancel got state=%0d disp=%h exp=0/0040", state, disp); end
    press_start();
    vectors++; if (disp !== 16'h0040) begin miscompares++; $display("FAIL cancel_reload got=%h exp=0040", disp); end
    press_start();
    press_mode();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL pause_cancel got=%0d exp=0", state); end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL prio_mode_start got=%0d exp=1", state); end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++; if (state !== 3'd1 || disp !== 16'h0040) begin
      miscompares++; $display("FAIL prio_start_inc got state=%0d disp=%h exp=1/0040", state, disp); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    vectors++; if (state !== 3'd2 || disp !== 16'h0040) begin
      miscompares++; $display("FAIL prio_mode_inc got state=%0d disp=%h exp=2/0040", state, disp); end
    press_start();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL set_sec_start got=%0d exp=2", state); end
    press_mode();
  endtask

  task automatic test_wrap();
    do_reset();
    press_inc(1);
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL idle_inc got=%h exp=0000", disp); end
    press_start();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL zero_start got=%0d exp=0", state); end
    press_mode();
    press_inc(59);
    vectors++; if (disp !== 16'h5900) begin miscompares++; $display("FAIL min_59 got=%h exp=5900", disp); end
    press_inc(1);
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL min_wrap got=%h exp=0000", disp); end
    press_mode();
    press_inc(59);
    vectors++; if (disp !== 16'h0059) begin miscompares++; $display("FAIL sec_59 got=%h exp=0059", disp); end
    press_inc(1);
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL sec_wrap got=%h exp=0000", disp); end
    press_mode();
    press_start();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL wrap_zero_start got=%0d exp=0", state); end
  endtask

  task automatic test_reset_midrun();
    load_preset(2, 10);
    press_start();
    vectors++; if (disp !== 16'h0210) begin miscompares++; $display("FAIL midrun_load got=%h exp=0210", disp); end
    do_reset();
    vectors++; if (state !== 3'd0 || disp !== 16'h0000 || alarm !== 1'b0 || running !== 1'b0) begin
      miscompares++; $display("FAIL midrun_reset got state=%0d disp=%h alarm=%b exp=0/0000/0", state, disp, alarm); end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    load_preset(0, 2);
    press_start();
    for (int k = 1; k <= 4; k++) begin
      ticks(1);
      vectors++; if (done !== (k % 2 == 0)) begin
        miscompares++; $display("FAIL reload_done%0d got=%b exp=%b", k, done, k % 2 == 0); end
      vectors++; if (disp !== ((k % 2 == 0) ? 16'h0002 : 16'h0001)) begin
        miscompares++; $display("FAIL reload_disp%0d got=%h", k, disp); end
      vectors++; if (state !== 3'd3 || alarm !== 1'b0) begin
        miscompares++; $display("FAIL reload_state%0d got state=%0d alarm=%b exp=3/0", k, state, alarm); end
    end
    press_mode();
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_set_preset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
    test_done_ack();
`endif
    test_borrow();
    test_pause();
    test_priority();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
